// File: rtl/pe_conv1d_engine_if.sv
// Router/controller-facing bus of the 1-D convolution PE: scratchpad load port,
// start/config, incoming partial sums and the result stream.
interface pe_conv1d_engine_if #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned STRIDE_W = 2
);
    logic                load_valid;
    logic                load_ready;
    logic                load_type;
    logic [IDX_W-1:0]    load_addr;
    logic [DATA_W-1:0]   load_data;
    logic                start;
    logic [STRIDE_W-1:0] cfg_stride;
    logic                cfg_psum_en;
    logic                psum_in_valid;
    logic                psum_in_ready;
    logic [OUT_W-1:0]    psum_in_data;
    logic                psum_out_valid;
    logic                psum_out_ready;
    logic [OUT_W-1:0]    psum_out_data;
    logic [IDX_W-1:0]    psum_out_idx;
    logic                busy;
    logic                done;

    modport master (
        output load_valid, load_type, load_addr, load_data, start, cfg_stride, cfg_psum_en,
        output psum_in_valid, psum_in_data, psum_out_ready,
        input  load_ready, psum_in_ready, psum_out_valid, psum_out_data, psum_out_idx, busy, done
    );

    modport slave (
        input  load_valid, load_type, load_addr, load_data, start, cfg_stride, cfg_psum_en,
        input  psum_in_valid, psum_in_data, psum_out_ready,
        output load_ready, psum_in_ready, psum_out_valid, psum_out_data, psum_out_idx, busy, done
    );
endinterface

// File: rtl/pe_conv1d_engine.sv
// Row-stationary 1-D convolution PE: sliding-window MAC with runtime stride, optional psum add.
// Define PE_OUT_SAT_EN for unsigned output saturation; otherwise the result wraps modulo 2^OUT_W.
module pe_conv1d_engine #(
    parameter int unsigned FILTER_LEN = 3,
    parameter int unsigned IFMAP_LEN  = 5,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned MAX_STRIDE = 2,
    parameter int unsigned IDX_W      = 5
) (
    input logic               clk,
    input logic               rst_n,
    pe_conv1d_engine_if.slave bus
);
    localparam int unsigned STRIDE_W = $clog2(MAX_STRIDE + 1);
    localparam int unsigned MUL_W    = 2 * DATA_W;
    localparam int unsigned PROD_W   = 2 * DATA_W + $clog2(FILTER_LEN) + 1;
    localparam int unsigned ACC_W    = (PROD_W > OUT_W + 1) ? PROD_W : OUT_W + 1;
    localparam int unsigned POS_W    = $clog2(IFMAP_LEN + MAX_STRIDE + 1);
    localparam int unsigned FA_W     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned IA_W     = (IFMAP_LEN > 1) ? $clog2(IFMAP_LEN) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAC  = 3'd1;
    localparam logic [2:0] S_PSUM = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [ACC_W-1:0] OUT_MAX = {{(ACC_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic [DATA_W-1:0]   r_filt [FILTER_LEN];
    logic [DATA_W-1:0]   r_ifm  [IFMAP_LEN];

    logic [2:0]          r_state,    w_next_state;
    logic [STRIDE_W-1:0] r_stride,   w_stride;
    logic                r_psum_en,  w_psum_en;
    logic [FA_W-1:0]     r_tap,      w_tap;
    logic [POS_W-1:0]    r_base,     w_base;
    logic [IDX_W-1:0]    r_win,      w_win;
    logic [ACC_W-1:0]    r_acc,      w_acc;
    logic                r_out_valid, w_out_valid;
    logic [OUT_W-1:0]    r_out_data, w_out_data;
    logic [IDX_W-1:0]    r_out_idx,  w_out_idx;
    logic                r_load_ready, r_busy, r_done, r_psum_in_ready;

    logic [STRIDE_W-1:0] w_stride_cfg;
    logic [POS_W-1:0]    w_ifm_pos;
    logic [MUL_W-1:0]    w_prod;
    logic [OUT_W-1:0]    w_reduced;

    // Scratchpad writes: only while idle; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (bus.load_valid && r_load_ready) begin
            if (bus.load_type) begin
                if (32'(bus.load_addr) < FILTER_LEN) r_filt[FA_W'(bus.load_addr)] <= bus.load_data;
            end else if (32'(bus.load_addr) < IFMAP_LEN) begin
                r_ifm[IA_W'(bus.load_addr)] <= bus.load_data;
            end
        end
    end

    always_comb begin
        w_stride_cfg = bus.cfg_stride;
        if (bus.cfg_stride == '0)                    w_stride_cfg = STRIDE_W'(1);
        else if (32'(bus.cfg_stride) > MAX_STRIDE)   w_stride_cfg = STRIDE_W'(MAX_STRIDE);
        w_ifm_pos = r_base + POS_W'(r_tap);
        w_prod    = MUL_W'(r_filt[r_tap]) * MUL_W'(r_ifm[IA_W'(w_ifm_pos)]);
`ifdef PE_OUT_SAT_EN
        w_reduced = (r_acc > OUT_MAX) ? {OUT_W{1'b1}} : OUT_W'(r_acc);
`else
        w_reduced = OUT_W'(r_acc);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_stride     = r_stride;
        w_psum_en    = r_psum_en;
        w_tap        = r_tap;
        w_base       = r_base;
        w_win        = r_win;
        w_acc        = r_acc;
        w_out_valid  = r_out_valid;
        w_out_data   = r_out_data;
        w_out_idx    = r_out_idx;
        case (r_state)
            S_IDLE: if (bus.start) begin
                w_stride     = w_stride_cfg;
                w_psum_en    = bus.cfg_psum_en;
                w_tap        = '0;
                w_base       = '0;
                w_win        = '0;
                w_acc        = '0;
                w_next_state = S_MAC;
            end
            S_MAC: begin
                w_acc = r_acc + ACC_W'(w_prod);
                if (r_tap == FA_W'(FILTER_LEN - 1)) begin
                    w_tap        = '0;
                    w_next_state = S_PSUM;
                end else begin
                    w_tap = r_tap + FA_W'(1);
                end
            end
            S_PSUM: begin
                if (!r_psum_en) begin
                    w_next_state = S_OUT;
                end else if (bus.psum_in_valid && r_psum_in_ready) begin
                    w_acc        = r_acc + ACC_W'(bus.psum_in_data);
                    w_next_state = S_OUT;
                end
            end
            // First OUT cycle registers the reduced result; it is then held until accepted.
            S_OUT: begin
                if (!r_out_valid) begin
                    w_out_valid = 1'b1;
                    w_out_data  = w_reduced;
                    w_out_idx   = r_win;
                end else if (bus.psum_out_ready) begin
                    w_out_valid  = 1'b0;
                    w_win        = r_win + IDX_W'(1);
                    w_acc        = '0;
                    w_base       = r_base + POS_W'(r_stride);
                    w_next_state = (32'(w_base) + FILTER_LEN > IFMAP_LEN) ? S_DONE : S_MAC;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stride        <= '0;
            r_psum_en       <= 1'b0;
            r_tap           <= '0;
            r_base          <= '0;
            r_win           <= '0;
            r_acc           <= '0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_idx       <= '0;
            r_load_ready    <= 1'b1;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_psum_in_ready <= 1'b0;
        end else begin
            r_stride        <= w_stride;
            r_psum_en       <= w_psum_en;
            r_tap           <= w_tap;
            r_base          <= w_base;
            r_win           <= w_win;
            r_acc           <= w_acc;
            r_out_valid     <= w_out_valid;
            r_out_data      <= w_out_data;
            r_out_idx       <= w_out_idx;
            r_load_ready    <= (w_next_state == S_IDLE);
            r_busy          <= (w_next_state != S_IDLE);
            r_done          <= (w_next_state == S_DONE);
            r_psum_in_ready <= (w_next_state == S_PSUM) && w_psum_en;
        end
    end

    assign bus.load_ready     = r_load_ready;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.psum_in_ready  = r_psum_in_ready;
    assign bus.psum_out_valid = r_out_valid;
    assign bus.psum_out_data  = r_out_data;
    assign bus.psum_out_idx   = r_out_idx;
endmodule

// File: tb/tb_pe_conv1d_engine.sv
// Scoreboard bench for pe_conv1d_engine: directed scenarios plus randomized runs
// checked against a plain-arithmetic convolution model.
module tb_pe_conv1d_engine;
    localparam int unsigned FILTER_LEN = 3;
    localparam int unsigned IFMAP_LEN  = 5;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned OUT_W      = 8;
    localparam int unsigned MAX_STRIDE = 2;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned STRIDE_W   = $clog2(MAX_STRIDE + 1);
    localparam longint      OUT_MAX    = (longint'(1) << OUT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pe_conv1d_engine_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .IDX_W(IDX_W), .STRIDE_W(STRIDE_W)) bus ();

    pe_conv1d_engine #(
        .FILTER_LEN(FILTER_LEN), .IFMAP_LEN(IFMAP_LEN), .DATA_W(DATA_W),
        .OUT_W(OUT_W), .MAX_STRIDE(MAX_STRIDE), .IDX_W(IDX_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_data_q[$];
    int exp_idx_q[$];
    int psum_q[$];
    int psum_gap_q[$];
    int rdy_gap_q[$];
    int out_cnt = 0;
    int done_cnt = 0;
    int first_valid_cyc = -1;
    int start_cyc = 0;

    int m_filt[FILTER_LEN];
    int m_ifm[IFMAP_LEN];
    int psum_val[8];
    int psum_gap[8];
    int rdy_gap[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented output with the scoreboard head, pop on acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.psum_out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check("output_expected", int'(exp_data_q.size() > 0), 1);
                if (exp_data_q.size() > 0) begin
                    check("out_data", int'(bus.psum_out_data), exp_data_q[0]);
                    check("out_idx", int'(bus.psum_out_idx), exp_idx_q[0]);
                    if (bus.psum_out_ready) begin
                        void'(exp_data_q.pop_front());
                        void'(exp_idx_q.pop_front());
                        out_cnt++;
                    end
                end
            end
            if (rst_n && bus.done) done_cnt++;
        end
    end

    // Output consumer: per-output programmable back-pressure.
    initial begin
        bit rdy_started;
        int rdy_stall;
        rdy_started = 1'b0;
        rdy_stall = 0;
        bus.psum_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.psum_out_valid) begin
                if (!rdy_started) begin
                    rdy_started = 1'b1;
                    rdy_stall = (rdy_gap_q.size() > 0) ? rdy_gap_q.pop_front() : 0;
                end
                if (rdy_stall > 0) begin
                    rdy_stall--;
                    bus.psum_out_ready = 1'b0;
                end else begin
                    bus.psum_out_ready = 1'b1;
                end
            end else begin
                bus.psum_out_ready = 1'b0;
                rdy_started = 1'b0;
            end
        end
    end

    // Partial-sum source: holds valid low for a programmed number of cycles the DUT is waiting.
    initial begin
        bit p_acc;
        bit p_gapset;
        int p_gap;
        p_gapset = 1'b0;
        p_gap = 0;
        bus.psum_in_valid = 1'b0;
        bus.psum_in_data = '0;
        forever begin
            @(negedge clk);
            p_acc = bus.psum_in_valid && bus.psum_in_ready;
            @(posedge clk);
            #1;
            if (p_acc) begin
                bus.psum_in_valid = 1'b0;
                void'(psum_q.pop_front());
                p_gapset = 1'b0;
            end
            if (!bus.psum_in_valid && psum_q.size() > 0) begin
                if (!p_gapset) begin
                    p_gap = psum_gap_q.pop_front();
                    p_gapset = 1'b1;
                end
                if (p_gap > 0) begin
                    if (bus.psum_in_ready) p_gap--;
                end else begin
                    bus.psum_in_valid = 1'b1;
                    bus.psum_in_data = OUT_W'(psum_q[0]);
                end
            end
        end
    end

    task automatic load_elem(input bit typ, input int addr, input int data);
        bus.load_valid = 1'b1;
        bus.load_type = typ;
        bus.load_addr = IDX_W'(addr);
        bus.load_data = DATA_W'(data);
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
    endtask

    task automatic load_model();
        check("load_ready_idle", int'(bus.load_ready), 1);
        for (int j = 0; j < int'(FILTER_LEN); j++) load_elem(1'b1, j, m_filt[j]);
        for (int i = 0; i < int'(IFMAP_LEN); i++) load_elem(1'b0, i, m_ifm[i]);
        // Out-of-range writes that would alias onto element 0 if not dropped.
        load_elem(1'b1, int'(FILTER_LEN) + 1, 99);
        load_elem(1'b0, int'(IFMAP_LEN) + 3, 77);
    endtask

    // Reference: direct convolution sum per window with the effective stride.
    task automatic push_expected(input int stride_cfg, input bit psum_en, output int nout);
        int s;
        longint acc;
        s = (stride_cfg == 0) ? 1 : ((stride_cfg > int'(MAX_STRIDE)) ? int'(MAX_STRIDE) : stride_cfg);
        nout = (int'(IFMAP_LEN) - int'(FILTER_LEN)) / s + 1;
        for (int w = 0; w < nout; w++) begin
            acc = 0;
            for (int j = 0; j < int'(FILTER_LEN); j++) acc += longint'(m_filt[j]) * longint'(m_ifm[w * s + j]);
            if (psum_en) begin
                acc += longint'(psum_val[w]);
                psum_q.push_back(psum_val[w]);
                psum_gap_q.push_back(psum_gap[w]);
            end
`ifdef PE_OUT_SAT_EN
            if (acc > OUT_MAX) acc = OUT_MAX;
`else
            acc = acc % (OUT_MAX + 1);
`endif
            exp_data_q.push_back(int'(acc));
            exp_idx_q.push_back(w);
            rdy_gap_q.push_back(rdy_gap[w]);
        end
    endtask

    task automatic run_case(input int stride_cfg, input bit psum_en, input bit chk_lat, input bit poke);
        int nout;
        int k;
        push_expected(stride_cfg, psum_en, nout);
        out_cnt = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
        bus.cfg_stride = STRIDE_W'(stride_cfg);
        bus.cfg_psum_en = psum_en;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
        bus.cfg_stride = STRIDE_W'($urandom);
        bus.cfg_psum_en = ~psum_en;
        if (poke) begin
            @(posedge clk);
            #1;
            check("load_ready_busy", int'(bus.load_ready), 0);
            check("busy_running", int'(bus.busy), 1);
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("done_before_timeout", int'(done_cnt > 0), 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt, 1);
        check("outputs_accepted", out_cnt, nout);
        check("scoreboard_empty", exp_data_q.size(), 0);
        check("busy_after_done", int'(bus.busy), 0);
        if (chk_lat) check("first_valid_latency", first_valid_cyc - start_cyc, int'(FILTER_LEN) + 2);
        exp_data_q.delete();
        exp_idx_q.delete();
        psum_q.delete();
        psum_gap_q.delete();
        rdy_gap_q.delete();
    endtask

    task automatic set_base_data();
        for (int j = 0; j < int'(FILTER_LEN); j++) m_filt[j] = j + 1;
        for (int i = 0; i < int'(IFMAP_LEN); i++) m_ifm[i] = i + 1;
    endtask

    task automatic clear_knobs();
        for (int w = 0; w < 8; w++) begin
            psum_val[w] = 0;
            psum_gap[w] = 0;
            rdy_gap[w] = 0;
        end
    endtask

    initial begin
        int seen;
        int k;
        bus.load_valid = 1'b0;
        bus.load_type = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start = 1'b0;
        bus.cfg_stride = '0;
        bus.cfg_psum_en = 1'b0;
        clear_knobs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_ready", int'(bus.load_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_out_valid", int'(bus.psum_out_valid), 0);
        check("rst_psum_in_ready", int'(bus.psum_in_ready), 0);
        check("rst_out_data", int'(bus.psum_out_data), 0);
        check("rst_out_idx", int'(bus.psum_out_idx), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Filter [1,2,3], ifmap [1..5]: 14, 20, 26
        set_base_data();
        load_model();
        run_case(1, 1'b0, 1'b1, 1'b0);
        run_case(2, 1'b0, 1'b1, 1'b0);
        run_case(0, 1'b0, 1'b1, 1'b0);
        run_case(3, 1'b0, 1'b1, 1'b1);

        // Partial sums 10/20/30 with the second one withheld while the PE waits.
        psum_val[0] = 10; psum_val[1] = 20; psum_val[2] = 30;
        psum_gap[1] = 4;
        run_case(1, 1'b1, 1'b0, 1'b0);
        clear_knobs();

        // Back-pressure on output 1 for six cycles.
        rdy_gap[1] = 6;
        run_case(1, 1'b0, 1'b1, 1'b0);
        clear_knobs();

        // All-ones data: saturates or wraps depending on build.
        for (int j = 0; j < int'(FILTER_LEN); j++) m_filt[j] = 255;
        for (int i = 0; i < int'(IFMAP_LEN); i++) m_ifm[i] = 255;
        load_model();
        run_case(1, 1'b0, 1'b1, 1'b0);

        // Abort during window 1 MAC, then reload and rerun.
        set_base_data();
        load_model();
        exp_data_q.push_back(14);
        exp_idx_q.push_back(0);
        out_cnt = 0;
        bus.cfg_stride = STRIDE_W'(1);
        bus.cfg_psum_en = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k = 0;
        while (out_cnt == 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("abort_first_output", out_cnt, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_out_valid", int'(bus.psum_out_valid), 0);
        check("abort_load_ready", int'(bus.load_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.psum_out_valid) seen++;
        end
        check("abort_no_output", seen, 0);
        @(posedge clk);
        #1;
        exp_data_q.delete();
        exp_idx_q.delete();
        rdy_gap_q.delete();
        load_model();
        run_case(1, 1'b0, 1'b1, 1'b0);

        // Randomized runs; every other run reuses the stored scratchpad.
        for (int it = 0; it < 24; it++) begin
            bit en;
            if (it % 2 == 0) begin
                for (int j = 0; j < int'(FILTER_LEN); j++) m_filt[j] = int'($urandom_range(0, 255));
                for (int i = 0; i < int'(IFMAP_LEN); i++) m_ifm[i] = int'($urandom_range(0, 255));
                load_model();
            end
            for (int w = 0; w < 8; w++) begin
                psum_val[w] = int'($urandom_range(0, 255));
                psum_gap[w] = int'($urandom_range(0, 3));
                rdy_gap[w] = int'($urandom_range(0, 3));
            end
            en = 1'($urandom_range(0, 1));
            run_case(int'($urandom_range(0, 3)), en, !en, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
